// File: rtl/ir_json_cmd_streamer.sv
// ir_json_cmd_streamer
//
// Turns 3-bit motion commands from the IR decoder into fixed 24-byte JSON
// frames of the form {"T":1,"L":<L>,"R":<R>}\n and streams them to uart_tx,
// one byte per valid/ready handshake. One command can be held pending while
// a frame is in flight. Optionally re-sends the last motion frame as a
// keepalive after REPEAT_CYCLES idle cycles.
//
// Ports:
//   iCLK        system clock
//   iRST_n      asynchronous active-low reset
//   iCMD_VALID  one-cycle strobe qualifying iCMD
//   iCMD        0=STOP 1=FWD 2=BACK 3=LEFT 4=RIGHT, 5..7 ignored
//   oTX_DATA    byte to uart_tx (0x00 when oTX_VALID is low)
//   oTX_VALID   byte valid to uart_tx
//   iTX_READY   uart_tx ready
//   oBUSY       high while sending a frame or in the post-frame gap cycle
//   oOVERWRITE  one-cycle pulse after a pending command was replaced
//   oFRAME_CNT  completed frame count, wraps at 16 bits
module ir_json_cmd_streamer #(
  parameter int unsigned REPEAT_CYCLES = 50_000_000,
  parameter int unsigned JSON_LEN      = 24
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iCMD_VALID,
  input  logic [2:0]  iCMD,
  output logic [7:0]  oTX_DATA,
  output logic        oTX_VALID,
  input  logic        iTX_READY,
  output logic        oBUSY,
  output logic        oOVERWRITE,
  output logic [15:0] oFRAME_CNT
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  // Speed value printed in a wheel field.
  typedef enum logic [1:0] {ValPos, ValNeg, ValZero} val_e;

  localparam logic [2:0] CmdStop  = 3'd0;
  localparam logic [2:0] CmdFwd   = 3'd1;
  localparam logic [2:0] CmdBack  = 3'd2;
  localparam logic [2:0] CmdLeft  = 3'd3;
  localparam logic [2:0] CmdRight = 3'd4;

  localparam logic [4:0]  LastIdx  = 5'(JSON_LEN - 1);
  localparam bit          KaEnable = (REPEAT_CYCLES != 0);
  // Guarded so a disabled keepalive does not produce an underflowed constant.
  localparam logic [31:0] KaLast   = KaEnable ? 32'(REPEAT_CYCLES - 1) : 32'd0;

  // Left wheel: positive for FWD/RIGHT, negative for BACK/LEFT.
  function automatic val_e left_val(input logic [2:0] cmd);
    val_e v;
    case (cmd)
      CmdFwd, CmdRight: v = ValPos;
      CmdBack, CmdLeft: v = ValNeg;
      default:          v = ValZero;
    endcase
    return v;
  endfunction

  // Right wheel: positive for FWD/LEFT, negative for BACK/RIGHT.
  function automatic val_e right_val(input logic [2:0] cmd);
    val_e v;
    case (cmd)
      CmdFwd, CmdLeft:   v = ValPos;
      CmdBack, CmdRight: v = ValNeg;
      default:           v = ValZero;
    endcase
    return v;
  endfunction

  // Three-character value field: "0.1", "-.1" or "0.0".
  function automatic logic [7:0] val_byte(input val_e v, input logic [1:0] pos);
    logic [7:0] b;
    case (pos)
      2'd0:    b = (v == ValNeg) ? 8'h2D : 8'h30;
      2'd1:    b = 8'h2E;
      2'd2:    b = (v == ValZero) ? 8'h30 : 8'h31;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] cmd, input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:                b = 8'h7B;  // {
      5'd1:                b = 8'h22;  // "
      5'd2:                b = 8'h54;  // T
      5'd3:                b = 8'h22;
      5'd4:                b = 8'h3A;  // :
      5'd5:                b = 8'h31;  // 1
      5'd6:                b = 8'h2C;  // ,
      5'd7:                b = 8'h22;
      5'd8:                b = 8'h4C;  // L
      5'd9:                b = 8'h22;
      5'd10:               b = 8'h3A;
      5'd11, 5'd12, 5'd13: b = val_byte(left_val(cmd), 2'(idx - 5'd11));
      5'd14:               b = 8'h2C;
      5'd15:               b = 8'h22;
      5'd16:               b = 8'h52;  // R
      5'd17:               b = 8'h22;
      5'd18:               b = 8'h3A;
      5'd19, 5'd20, 5'd21: b = val_byte(right_val(cmd), 2'(idx - 5'd19));
      5'd22:               b = 8'h7D;  // }
      5'd23:               b = 8'h0A;  // \n
      default:             b = 8'h00;
    endcase
    return b;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [2:0]  cur_cmd_q, cur_cmd_d;    // command of the frame in flight
  logic [2:0]  last_cmd_q, last_cmd_d;  // most recently started frame, for keepalive
  logic        pend_valid_q, pend_valid_d;
  logic [2:0]  pend_cmd_q, pend_cmd_d;
  logic [31:0] ka_cnt_q, ka_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        ovw_q, ovw_d;

  logic       cmd_ok;
  logic       handshake;
  logic       start;
  logic [2:0] start_cmd;

  assign cmd_ok    = iCMD_VALID && (iCMD <= CmdRight);
  assign handshake = (state_q == StSend) && iTX_READY;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cur_cmd_d    = cur_cmd_q;
    last_cmd_d   = last_cmd_q;
    pend_valid_d = pend_valid_q;
    pend_cmd_d   = pend_cmd_q;
    ka_cnt_d     = ka_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    ovw_d        = 1'b0;
    start        = 1'b0;
    start_cmd    = iCMD;

    case (state_q)
      StIdle: begin
        if (cmd_ok) begin
          start     = 1'b1;
          start_cmd = iCMD;
        end else if (KaEnable && (last_cmd_q != CmdStop)) begin
          if (ka_cnt_q == KaLast) begin
            start     = 1'b1;
            start_cmd = last_cmd_q;
          end else begin
            ka_cnt_d = ka_cnt_q + 32'd1;
          end
        end
      end

      StSend: begin
        // The frame in flight is never touched; new commands only queue.
        if (cmd_ok) begin
          ovw_d        = pend_valid_q;
          pend_valid_d = 1'b1;
          pend_cmd_d   = iCMD;
        end
        if (handshake) begin
          if (idx_q == LastIdx) begin
            state_d     = StGap;
            idx_d       = 5'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      StGap: begin
        // A fresh command outranks the pending one; either way the slot empties.
        pend_valid_d = 1'b0;
        state_d      = StIdle;
        if (cmd_ok) begin
          start     = 1'b1;
          start_cmd = iCMD;
        end else if (pend_valid_q) begin
          start     = 1'b1;
          start_cmd = pend_cmd_q;
        end
      end

      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d    = StSend;
      idx_d      = 5'd0;
      cur_cmd_d  = start_cmd;
      last_cmd_d = start_cmd;
      ka_cnt_d   = 32'd0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= StIdle;
      idx_q        <= 5'd0;
      cur_cmd_q    <= CmdStop;
      last_cmd_q   <= CmdStop;
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= CmdStop;
      ka_cnt_q     <= 32'd0;
      frame_cnt_q  <= 16'd0;
      ovw_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cur_cmd_q    <= cur_cmd_d;
      last_cmd_q   <= last_cmd_d;
      pend_valid_q <= pend_valid_d;
      pend_cmd_q   <= pend_cmd_d;
      ka_cnt_q     <= ka_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      ovw_q        <= ovw_d;
    end
  end

  // Outputs decode straight from registers so reset clears them immediately.
  always_comb begin
    oTX_VALID  = (state_q == StSend);
    oTX_DATA   = oTX_VALID ? frame_byte(cur_cmd_q, idx_q) : 8'h00;
    oBUSY      = (state_q != StIdle);
    oOVERWRITE = ovw_q;
    oFRAME_CNT = frame_cnt_q;
  end

endmodule

// File: tb/tb_ir_json_cmd_streamer.sv
// Bench for ir_json_cmd_streamer: a frame-level reference model checked every
// cycle, plus directed scenarios with literal byte expectations.
module tb_ir_json_cmd_streamer;

  localparam int unsigned RepCycles = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic        ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        overwrite;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  ir_json_cmd_streamer #(
    .REPEAT_CYCLES(RepCycles),
    .JSON_LEN     (24)
  ) dut (
    .iCLK      (clk),
    .iRST_n    (rst_n),
    .iCMD_VALID(cmd_valid),
    .iCMD      (cmd),
    .oTX_DATA  (tx_data),
    .oTX_VALID (tx_valid),
    .iTX_READY (ready),
    .oBUSY     (busy),
    .oOVERWRITE(overwrite),
    .oFRAME_CNT(frame_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame built from its textual form.
  function automatic logic [7:0] frame_byte(input logic [2:0] c, input int unsigned i);
    string l, r, s;
    case (c)
      3'd1:    begin l = "0.1"; r = "0.1"; end
      3'd2:    begin l = "-.1"; r = "-.1"; end
      3'd3:    begin l = "-.1"; r = "0.1"; end
      3'd4:    begin l = "0.1"; r = "-.1"; end
      default: begin l = "0.0"; r = "0.0"; end
    endcase
    s = $sformatf("{\"T\":1,\"L\":%s,\"R\":%s}\n", l, r);
    return s[i];
  endfunction

  logic [7:0] fwd_lit [24] = '{8'h7B, 8'h22, 8'h54, 8'h22, 8'h3A, 8'h31, 8'h2C, 8'h22,
                               8'h4C, 8'h22, 8'h3A, 8'h30, 8'h2E, 8'h31, 8'h2C, 8'h22,
                               8'h52, 8'h22, 8'h3A, 8'h30, 8'h2E, 8'h31, 8'h7D, 8'h0A};

  // ---------------- reference model ----------------
  bit          m_send, m_gap, m_pend_v, m_ovw;
  logic [2:0]  m_cmd, m_pend_c, m_last;
  int unsigned m_pos, m_idle;
  logic [15:0] m_cnt;
  logic        m_ok;
  logic        m_start;
  logic [2:0]  m_start_cmd;

  assign m_ok = cmd_valid && (cmd <= 3'd4);

  always_comb begin
    m_start     = 1'b0;
    m_start_cmd = cmd;
    if (!m_send && m_gap) begin
      if (m_ok) m_start = 1'b1;
      else if (m_pend_v) begin
        m_start     = 1'b1;
        m_start_cmd = m_pend_c;
      end
    end else if (!m_send && !m_gap) begin
      if (m_ok) m_start = 1'b1;
      else if (RepCycles != 0 && m_last != 3'd0 && m_idle == RepCycles - 1) begin
        m_start     = 1'b1;
        m_start_cmd = m_last;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_send <= 0; m_gap <= 0; m_pend_v <= 0; m_ovw <= 0;
      m_cmd <= 0; m_pend_c <= 0; m_last <= 0; m_pos <= 0; m_idle <= 0; m_cnt <= 0;
    end else begin
      m_ovw <= 1'b0;
      if (m_send) begin
        if (m_ok) begin
          m_ovw    <= m_pend_v;
          m_pend_v <= 1'b1;
          m_pend_c <= cmd;
        end
        if (ready) begin
          if (m_pos == 23) begin
            m_send <= 1'b0;
            m_gap  <= 1'b1;
            m_pos  <= 0;
            m_cnt  <= m_cnt + 16'd1;
          end else begin
            m_pos <= m_pos + 1;
          end
        end
      end else if (m_gap) begin
        m_gap    <= 1'b0;
        m_pend_v <= 1'b0;
      end else if (!m_start && RepCycles != 0 && m_last != 3'd0) begin
        m_idle <= m_idle + 1;
      end
      if (m_start) begin
        m_send <= 1'b1;
        m_pos  <= 0;
        m_cmd  <= m_start_cmd;
        m_last <= m_start_cmd;
        m_idle <= 0;
      end
    end
  end

  // ---------------- compare + monitors ----------------
  logic [7:0] cap[$];
  int         start_cyc[$];
  int         ovw_cnt = 0;
  int         cyc = 0;

  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_send});
        chk("busy", {31'd0, busy}, {31'd0, m_send | m_gap});
        chk("overwrite", {31'd0, overwrite}, {31'd0, m_ovw});
        chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
        if (m_send) chk("tx_data", {24'd0, tx_data}, {24'd0, frame_byte(m_cmd, m_pos)});
        if (tx_valid && ready) cap.push_back(tx_data);
        if (tx_valid && !prev_v) start_cyc.push_back(cyc);
        if (overwrite) ovw_cnt++;
        prev_v = tx_valid;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
    cmd       = 3'd0;
  endtask

  task automatic clear_mon();
    cap.delete();
    start_cyc.delete();
    ovw_cnt = 0;
  endtask

  task automatic do_reset();
    ready     = 1'b0;
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    repeat (2) tick();
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovw", {31'd0, overwrite}, 32'd0);
    chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();
    clear_mon();
  endtask

  task automatic wait_caps(input int n, input int budget, input string name);
    int k = 0;
    while (cap.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, {31'd0, cap.size() >= n}, 32'd1);
  endtask

  task automatic chk_field(input string name, input int base, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2);
    if (cap.size() >= base + 3) begin
      chk({name, "_0"}, {24'd0, cap[base]},     {24'd0, b0});
      chk({name, "_1"}, {24'd0, cap[base + 1]}, {24'd0, b1});
      chk({name, "_2"}, {24'd0, cap[base + 2]}, {24'd0, b2});
    end else begin
      chk({name, "_len"}, cap.size(), base + 3);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n0;

    // FWD with ready tied high: 24 consecutive bytes, then one gap cycle.
    do_reset();
    ready = 1'b1;
    send_cmd(3'd1);
    chk("fwd_lat_valid", {31'd0, tx_valid}, 32'd1);
    chk("fwd_lat_data", {24'd0, tx_data}, 32'h7B);
    repeat (23) tick();
    chk("fwd_last_data", {24'd0, tx_data}, 32'h0A);
    tick();
    chk("fwd_gap_valid", {31'd0, tx_valid}, 32'd0);
    chk("fwd_gap_busy", {31'd0, busy}, 32'd1);
    chk("fwd_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("fwd_len", cap.size(), 32'd24);
    for (int i = 0; i < 24; i++) begin
      if (i < cap.size()) chk($sformatf("fwd_byte%0d", i), {24'd0, cap[i]}, {24'd0, fwd_lit[i]});
    end
    tick();
    chk("fwd_idle_busy", {31'd0, busy}, 32'd0);

    // LEFT with ready pulsing once every ten cycles.
    do_reset();
    send_cmd(3'd3);
    for (int i = 0; i < 400 && cap.size() < 24; i++) begin
      ready = (i % 10 == 9);
      tick();
    end
    ready = 1'b0;
    chk("left_len", cap.size(), 32'd24);
    chk_field("left_l", 11, 8'h2D, 8'h2E, 8'h31);
    chk_field("left_r", 19, 8'h30, 8'h2E, 8'h31);
    repeat (3) tick();
    chk("left_cnt", {16'd0, frame_cnt}, 32'd1);

    // BACK in flight; RIGHT then STOP queued -> RIGHT overwritten, STOP follows.
    do_reset();
    ready = 1'b1;
    send_cmd(3'd2);
    repeat (2) tick();
    send_cmd(3'd4);
    repeat (2) tick();
    send_cmd(3'd0);
    wait_caps(48, 200, "ovw_wait");
    chk("ovw_pulses", ovw_cnt, 32'd1);
    chk_field("ovw_back_l", 11, 8'h2D, 8'h2E, 8'h31);
    chk_field("ovw_back_r", 19, 8'h2D, 8'h2E, 8'h31);
    chk_field("ovw_stop_l", 35, 8'h30, 8'h2E, 8'h30);
    chk_field("ovw_stop_r", 43, 8'h30, 8'h2E, 8'h30);
    if (start_cyc.size() >= 2) chk("ovw_gap", start_cyc[1] - start_cyc[0], 32'd25);
    else chk("ovw_starts", start_cyc.size(), 32'd2);
    repeat (300) tick();
    chk("ovw_total", cap.size(), 32'd48);
    chk("ovw_cnt", {16'd0, frame_cnt}, 32'd2);

    // Keepalive: frame start every 24 + 1 + 100 cycles, stopped by STOP.
    do_reset();
    ready = 1'b1;
    send_cmd(3'd1);
    for (int i = 0; i < 600 && start_cyc.size() < 3; i++) tick();
    chk("ka_starts", {31'd0, start_cyc.size() >= 3}, 32'd1);
    if (start_cyc.size() >= 3) begin
      chk("ka_period1", start_cyc[1] - start_cyc[0], 32'd125);
      chk("ka_period2", start_cyc[2] - start_cyc[1], 32'd125);
    end
    repeat (30) tick();
    n0 = start_cyc.size();
    send_cmd(3'd0);
    repeat (1000) tick();
    chk("ka_stop_starts", start_cyc.size(), n0 + 1);
    chk("ka_stop_len", cap.size(), 32'd96);
    chk_field("ka_stop_l", 83, 8'h30, 8'h2E, 8'h30);
    chk("ka_cnt", {16'd0, frame_cnt}, 32'd4);

    // Asynchronous reset at byte 12 with a command pending.
    do_reset();
    ready = 1'b1;
    send_cmd(3'd1);
    repeat (26) tick();
    chk("ar_cnt_before", {16'd0, frame_cnt}, 32'd1);
    send_cmd(3'd1);
    send_cmd(3'd4);
    repeat (11) tick();
    chk("ar_byte12", {24'd0, tx_data}, 32'h2E);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, tx_valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_cnt", {16'd0, frame_cnt}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    n0 = start_cyc.size();
    repeat (200) tick();
    chk("ar_no_frame", start_cyc.size(), n0);
    chk("ar_cnt_after", {16'd0, frame_cnt}, 32'd0);

    // Invalid code 6/7 in IDLE and in SEND is ignored.
    do_reset();
    ready = 1'b1;
    send_cmd(3'd6);
    repeat (50) tick();
    chk("inv_idle_starts", start_cyc.size(), 32'd0);
    chk("inv_idle_busy", {31'd0, busy}, 32'd0);
    send_cmd(3'd1);
    tick();
    send_cmd(3'd4);
    tick();
    send_cmd(3'd6);
    send_cmd(3'd7);
    wait_caps(48, 200, "inv_wait");
    chk("inv_ovw", ovw_cnt, 32'd0);
    chk_field("inv_right_l", 35, 8'h30, 8'h2E, 8'h31);
    chk_field("inv_right_r", 43, 8'h2D, 8'h2E, 8'h31);
    repeat (5) tick();
    chk("inv_cnt", {16'd0, frame_cnt}, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
